// File: rtl/alu_pkg.sv
// Shared ALU encodings: select codes, ALUOp codes, R-type funct values and the
// S1 control payload used by the execute issue block.
package alu_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 6;

  // ALU select codes; 101-111 are never driven
  localparam logic [SEL_W-1:0] SEL_AND = 3'b000;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b001;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SUB = 3'b011;
  localparam logic [SEL_W-1:0] SEL_SLT = 3'b100;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ILL   = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             err;
    logic             is_branch;
  } s1_ctrl_t;

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational ALUOp/funct to ALU select translation; illegal ops map to ADD
// with the error flag raised.
module alu_sel_decode
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [SEL_W-1:0]   sel_c,
  output logic               err_c
);

  always_comb begin
    sel_c = SEL_ADD;
    err_c = 1'b0;
    case (aluop)
      ALUOP_ADD: sel_c = SEL_ADD;
      ALUOP_SUB: sel_c = SEL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: sel_c = SEL_ADD;
          FUNCT_SUB: sel_c = SEL_SUB;
          FUNCT_AND: sel_c = SEL_AND;
          FUNCT_OR:  sel_c = SEL_OR;
          FUNCT_SLT: sel_c = SEL_SLT;
          default:   err_c = 1'b1;
        endcase
      end
      default: err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_issue.sv
// Two-stage execute front end driving an external 32-bit ALU over valid/ready.
// Optional completed-op counter (op_count) enabled by defining ALU_STATS_EN.
module alu_exec_issue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
`ifdef ALU_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic [FUNCT_W-1:0]  in_funct,
  input  logic                in_is_branch,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [SEL_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_taken,
  output logic                out_err
`ifdef ALU_STATS_EN
  ,
  output logic [CNT_W-1:0]    op_count
`endif
);

  logic [SEL_W-1:0]  dec_sel;
  logic              dec_err;

  logic              s1_valid;
  s1_ctrl_t          s1_ctrl;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              adv1;
  logic              adv2;
  logic              in_fire;

  alu_sel_decode u_dec (
    .aluop (in_aluop),
    .funct (in_funct),
    .sel_c (dec_sel),
    .err_c (dec_err)
  );

  // Stall chain depends only on stage valids and out_ready, never on in_valid
  always_comb begin
    adv2    = !out_valid || out_ready;
    adv1    = !s1_valid || adv2;
    in_fire = in_valid && adv1;
  end

  assign in_ready = adv1;

  // ALU is driven straight from S1 whether or not S1 holds a live op
  assign alu_a   = s1_a;
  assign alu_b   = s1_b;
  assign alu_sel = s1_ctrl.sel;

  // Stage 1: decoded op and operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_ctrl.sel       <= dec_sel;
        s1_ctrl.err       <= dec_err;
        s1_ctrl.is_branch <= in_is_branch;
        s1_a              <= in_a;
        s1_b              <= in_b;
      end
    end
  end

  // Stage 2: captured ALU result; data only changes when a live op moves in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_taken  <= 1'b0;
      out_err    <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s1_ctrl.err ? '0 : alu_out;
        out_taken  <= s1_ctrl.is_branch && alu_zero && !s1_ctrl.err;
        out_err    <= s1_ctrl.err;
      end
    end
  end

`ifdef ALU_STATS_EN
  // Saturating count of delivered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != '1)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_issue.sv
// Randomized and directed bench for alu_exec_issue with a behavioural ALU and
// a queue-based reference model; define ALU_STATS_EN to cover op_count.
module tb_alu_exec_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic        in_is_branch;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_taken;
  logic        out_err;
`ifdef ALU_STATS_EN
  logic [3:0]  op_count;
  int          cnt_model;
`endif

  alu_exec_issue #(
    .DATA_W(32)
`ifdef ALU_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluop     (in_aluop),
    .in_funct     (in_funct),
    .in_is_branch (in_is_branch),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_taken    (out_taken),
    .out_err      (out_err)
`ifdef ALU_STATS_EN
    , .op_count   (op_count)
`endif
  );

  // Behavioural ALU: SLT is an unsigned compare, zero is A==B
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a + alu_b;
      3'b010:  alu_out = alu_a | alu_b;
      3'b011:  alu_out = alu_a - alu_b;
      3'b100:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_a == alu_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        taken;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          n_out;
  bit          strict_lat;
  bit          held_v;
  logic [31:0] held_res;
  logic        held_taken;
  logic        held_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: what a decoded op should produce, from the opcode rules alone
  function automatic exp_t ref_op(input logic [1:0] op, input logic [5:0] fn,
                                  input logic br, input logic [31:0] a,
                                  input logic [31:0] b);
    exp_t e;
    bit   legal;
    legal = 1'b1;
    e.res = 32'd0;
    case (op)
      2'd0: e.res = a + b;
      2'd1: e.res = a - b;
      2'd2: begin
        if (fn == 6'd32)      e.res = a + b;
        else if (fn == 6'd34) e.res = a - b;
        else if (fn == 6'd36) e.res = a & b;
        else if (fn == 6'd37) e.res = a | b;
        else if (fn == 6'd42) e.res = (a < b) ? 32'd1 : 32'd0;
        else                  legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) e.res = 32'd0;
    e.err   = !legal;
    e.taken = legal && br && (a == b);
    e.cyc   = 0;
    return e;
  endfunction

  task automatic step(input bit v, input logic [1:0] op, input logic [5:0] fn,
                      input bit br, input logic [31:0] a, input logic [31:0] b,
                      input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid     = v;
    in_aluop     = op;
    in_funct     = fn;
    in_is_branch = br;
    in_a         = a;
    in_b         = b;
    out_ready    = ordy;
    #1;
    if (held_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, held_res);
      chk("hold_taken", 32'(out_taken), 32'(held_taken));
      chk("hold_err", 32'(out_err), 32'(held_err));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", out_result, e.res);
        chk("taken", 32'(out_taken), 32'(e.taken));
        chk("err", 32'(out_err), 32'(e.err));
        if (strict_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
      n_out++;
    end
    held_v     = out_valid && !out_ready;
    held_res   = out_result;
    held_taken = out_taken;
    held_err   = out_err;
`ifdef ALU_STATS_EN
    chk("op_count", 32'(op_count), 32'(cnt_model));
    if (out_valid && out_ready && cnt_model != 15) cnt_model++;
`endif
    if (in_valid && in_ready) begin
      e     = ref_op(op, fn, br, a, b);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 2'd0, 6'd0, 1'b0, 32'd0, 32'd0, ordy);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      idle(1'b1);
      budget++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  logic [5:0] legal_fn[5];
  int         out_base;

  initial begin
    legal_fn[0] = 6'd32; legal_fn[1] = 6'd34; legal_fn[2] = 6'd36;
    legal_fn[3] = 6'd37; legal_fn[4] = 6'd42;
    n_checks = 0; n_errors = 0; cyc = 0; n_out = 0;
    strict_lat = 1'b0; held_v = 1'b0;
    held_res = '0; held_taken = 1'b0; held_err = 1'b0;
`ifdef ALU_STATS_EN
    cnt_model = 0;
`endif
    rst = 1'b1;
    in_valid = 1'b0; in_aluop = '0; in_funct = '0; in_is_branch = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back R-type stream with a fixed two-cycle latency
    strict_lat = 1'b1;
    step(1'b1, 2'd2, 6'd32, 1'b0, 32'd5,    32'd7,    1'b1);
    step(1'b1, 2'd2, 6'd34, 1'b0, 32'd7,    32'd5,    1'b1);
    step(1'b1, 2'd2, 6'd36, 1'b0, 32'hF0,   32'h3C,   1'b1);
    step(1'b1, 2'd2, 6'd37, 1'b0, 32'hF0,   32'h0F,   1'b1);
    step(1'b1, 2'd2, 6'd42, 1'b0, 32'd3,    32'd9,    1'b1);
    // Branch compares, then illegal ops
    step(1'b1, 2'd1, 6'd0,  1'b1, 32'h1234, 32'h1234, 1'b1);
    step(1'b1, 2'd1, 6'd0,  1'b1, 32'h1234, 32'h1235, 1'b1);
    step(1'b1, 2'd2, 6'd0,  1'b1, 32'h55,   32'h55,   1'b1);
    step(1'b1, 2'd3, 6'd32, 1'b1, 32'h9,    32'h9,    1'b1);
    drain();
    strict_lat = 1'b0;

    // Backpressure: 3-op burst against 4 stalled cycles
    out_base = n_out;
    step(1'b1, 2'd0, 6'd0, 1'b0, 32'd100, 32'd1, 1'b0);
    step(1'b1, 2'd0, 6'd0, 1'b0, 32'd200, 32'd2, 1'b0);
    step(1'b1, 2'd0, 6'd0, 1'b0, 32'd300, 32'd3, 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'd0, 6'd0, 1'b0, 32'd300, 32'd3, 1'b0);
    chk("bp_in_ready2", 32'(in_ready), 32'd0);
    step(1'b1, 2'd0, 6'd0, 1'b0, 32'd300, 32'd3, 1'b1);
    idle(1'b1);
    drain();
    chk("bp_delivered", 32'(n_out - out_base), 32'd3);

    // Reset mid-stream with both stages full
    step(1'b1, 2'd0, 6'd0, 1'b0, 32'd11, 32'd22, 1'b0);
    step(1'b1, 2'd2, 6'd37, 1'b0, 32'd44, 32'd3, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    exp_q.delete();
    held_v = 1'b0;
`ifdef ALU_STATS_EN
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    cnt_model = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    chk("no_replay", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) fn = legal_fn[$urandom_range(0, 4)];
      else                          fn = 6'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step(1'($urandom_range(0, 3) != 0), op, fn, 1'($urandom),
           a, b, 1'($urandom_range(0, 2) != 0));
    end
    drain();
`ifdef ALU_STATS_EN
    chk("op_count_sat", 32'(op_count), 32'd15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
